errors_capture: RTL and testbench

Sticky error capture block, successor to the single-mode first-error locker. Latches unmasked error flags per bit. Records the pattern and timestamp of the first erroring cycle, and keeps per-bit saturating occurrence counters. Supports two capture modes: first-event lock and accumulate. Supports a runtime clear and raises an interrupt pulse on first capture. Sits beside datapath blocks (MAC, FIFO, CDC) and feeds status/CSR logic.

---
 rtl/errors_capture.sv | 117 +++++++++++
 tb/tb_errors_capture.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/errors_capture.sv
// Sticky error capture: per-bit latch, first-event pattern/timestamp, per-bit
// saturating occurrence counters, lock/accumulate modes, runtime clear and IRQ.
module errors_capture_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clear,
    input  logic             hit,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (srst)
            cnt <= '0;
        else if (clear)
            cnt <= CNT_W'(hit);
        else if (hit && !(&cnt))
            cnt <= cnt + CNT_W'(1);
    end
endmodule

module errors_capture #(
    parameter int BITS  = 8,
    parameter int CNT_W = 8,
    parameter int TS_W  = 32
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [BITS-1:0]       i_errors,
    input  logic [BITS-1:0]       i_mask,
    input  logic                  i_mode,
    input  logic                  i_clear,
    output logic [BITS-1:0]       o_errors,
    output logic [BITS-1:0]       o_first,
    output logic [TS_W-1:0]       o_first_ts,
    output logic                  o_locked,
    output logic                  o_irq,
    output logic [BITS*CNT_W-1:0] o_counts
);
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                      state, state_nxt;
    logic [BITS-1:0]             e;
    logic [TS_W-1:0]             ts;
    logic [BITS-1:0]             errors_nxt, first_nxt;
    logic [TS_W-1:0]             first_ts_nxt;
    logic                        irq_nxt;
    logic [BITS-1:0][CNT_W-1:0]  cnt;

    assign e        = i_errors & ~i_mask;
    assign o_locked = (state == LOCKED);
    assign o_counts = cnt;

    // Free-running timestamp; only srst touches it, clear does not.
    always_ff @(posedge clk) begin
        if (srst) ts <= '0;
        else      ts <= ts + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state      <= IDLE;
            o_errors   <= '0;
            o_first    <= '0;
            o_first_ts <= '0;
            o_irq      <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_errors   <= errors_nxt;
            o_first    <= first_nxt;
            o_first_ts <= first_ts_nxt;
            o_irq      <= irq_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        errors_nxt   = o_errors;
        first_nxt    = o_first;
        first_ts_nxt = o_first_ts;
        irq_nxt      = 1'b0;
        // Clear restarts from empty IDLE using this cycle's errors, so none are lost.
        if (i_clear) begin
            errors_nxt   = e;
            first_nxt    = e;
            first_ts_nxt = ts;
            irq_nxt      = |e;
            state_nxt    = (|e) ? LOCKED : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (|e) begin
                        errors_nxt   = e;
                        first_nxt    = e;
                        first_ts_nxt = ts;
                        irq_nxt      = 1'b1;
                        state_nxt    = LOCKED;
                    end
                end
                LOCKED: begin
                    if (i_mode) errors_nxt = o_errors | e;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < BITS; i++) begin : g_cnt
        errors_capture_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .srst  (srst),
            .clear (i_clear),
            .hit   (e[i]),
            .cnt   (cnt[i])
        );
    end
endmodule

// File: tb/tb_errors_capture.sv
// Scoreboard bench for errors_capture: each driven cycle pushes the expected
// registered outputs, which are popped and compared one edge later.
module tb_errors_capture;
    localparam int BITS = 4, CNT_W = 3, TS_W = 8;

    logic                  clk = 1'b0;
    logic                  srst = 1'b0;
    logic [BITS-1:0]       i_errors = '0, i_mask = '0;
    logic                  i_mode = 1'b0, i_clear = 1'b0;
    logic [BITS-1:0]       o_errors, o_first;
    logic [TS_W-1:0]       o_first_ts;
    logic                  o_locked, o_irq;
    logic [BITS*CNT_W-1:0] o_counts;

    errors_capture #(.BITS(BITS), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
        .clk(clk), .srst(srst), .i_errors(i_errors), .i_mask(i_mask),
        .i_mode(i_mode), .i_clear(i_clear), .o_errors(o_errors), .o_first(o_first),
        .o_first_ts(o_first_ts), .o_locked(o_locked), .o_irq(o_irq), .o_counts(o_counts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                  chk;
        logic [BITS-1:0]       er;
        logic [BITS-1:0]       fi;
        logic [TS_W-1:0]       ts;
        logic                  lk;
        logic                  irq;
        logic [BITS*CNT_W-1:0] cn;
        string                 nm;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    logic [TS_W-1:0] tb_ts = '0;

    // Spec timestamp: cleared by srst, otherwise +1 per cycle modulo 2^TS_W.
    always @(posedge clk) tb_ts <= srst ? '0 : tb_ts + 8'd1;

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            if (cur.chk) begin
                checks++;
                if ({o_errors, o_first, o_first_ts, o_locked, o_irq, o_counts} !==
                    {cur.er, cur.fi, cur.ts, cur.lk, cur.irq, cur.cn}) begin
                    errors++;
                    $display("FAIL %s: got err=%b first=%b ts=%0d lk=%b irq=%b cnt=%h, expected err=%b first=%b ts=%0d lk=%b irq=%b cnt=%h",
                             cur.nm, o_errors, o_first, o_first_ts, o_locked, o_irq, o_counts,
                             cur.er, cur.fi, cur.ts, cur.lk, cur.irq, cur.cn);
                end
            end
        end
    end

    function automatic logic [11:0] cnts(input int c3, input int c2, input int c1, input int c0);
        return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    endfunction

    function automatic exp_t mk(input string nm, input logic [3:0] er, input logic [3:0] fi,
                                input logic [7:0] ts, input logic lk, input logic irq,
                                input logic [11:0] cn);
        exp_t x;
        x.chk = 1'b1; x.er = er; x.fi = fi; x.ts = ts; x.lk = lk; x.irq = irq; x.cn = cn; x.nm = nm;
        return x;
    endfunction

    // Drive one cycle of stimulus and queue what the outputs must show after it.
    task automatic cyc(input logic [3:0] err, input logic [3:0] msk, input logic md,
                       input logic clr, input logic rst, input exp_t x);
        @(negedge clk);
        i_errors = err; i_mask = msk; i_mode = md; i_clear = clr; srst = rst;
        sb.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, mk("srst", 0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_reset();
        do_reset();
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, mk("reset_state", 0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_first_lock();
        while (tb_ts != 8'd5)
            cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, mk("idle_pre5", 0, 0, 0, 0, 0, 0));
        cyc(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, mk("first_cap", 4'b0010, 4'b0010, 5, 1, 1, cnts(0, 0, 1, 0)));
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, mk("irq_one_cycle", 4'b0010, 4'b0010, 5, 1, 0, cnts(0, 0, 1, 0)));
    endtask

    task automatic test_lock_hold();
        for (int k = 1; k <= 10; k++)
            cyc(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0,
                mk("lock_hold_sat", 4'b0010, 4'b0010, 5, 1, 0, cnts((k > 7) ? 7 : k, 0, 1, 0)));
    endtask

    task automatic test_accumulate();
        logic [7:0] t;
        do_reset();
        t = tb_ts;
        cyc(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, mk("acc_cap", 4'b0001, 4'b0001, t, 1, 1, cnts(0, 0, 0, 1)));
        cyc(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, mk("acc_or1", 4'b0101, 4'b0001, t, 1, 0, cnts(0, 1, 0, 1)));
        cyc(4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, mk("acc_or2", 4'b1101, 4'b0001, t, 1, 0, cnts(1, 1, 0, 1)));
        cyc(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, mk("mode_to_lock", 4'b1101, 4'b0001, t, 1, 0, cnts(1, 1, 1, 1)));
        cyc(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, mk("mode_to_acc", 4'b1111, 4'b0001, t, 1, 0, cnts(1, 1, 2, 1)));
    endtask

    task automatic test_mask();
        logic [7:0] t;
        do_reset();
        cyc(4'b0011, 4'b0011, 1'b0, 1'b0, 1'b0, mk("masked_ignored", 0, 0, 0, 0, 0, 0));
        t = tb_ts;
        cyc(4'b0111, 4'b0011, 1'b0, 1'b0, 1'b0, mk("mask_partial", 4'b0100, 4'b0100, t, 1, 1, cnts(0, 1, 0, 0)));
        cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, mk("unmask_no_change", 4'b0100, 4'b0100, t, 1, 0, cnts(0, 1, 0, 0)));
    endtask

    task automatic test_clear();
        logic [7:0] t;
        do_reset();
        t = tb_ts;
        for (int k = 1; k <= 3; k++)
            cyc(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, mk("pre_clear", 4'b0001, 4'b0001, t, 1, (k == 1), cnts(0, 0, 0, k)));
        while (tb_ts != 8'd40)
            cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, mk("wait_ts40", 4'b0001, 4'b0001, t, 1, 0, cnts(0, 0, 0, 3)));
        cyc(4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, mk("clear_with_err", 4'b0010, 4'b0010, 40, 1, 1, cnts(0, 0, 1, 0)));
        t = tb_ts;
        cyc(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, mk("clear_empty", 0, 0, t, 0, 0, 0));
    endtask

    task automatic test_back_to_back();
        logic [7:0] t;
        t = tb_ts;
        cyc(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, mk("b2b_clear1", 4'b0100, 4'b0100, t, 1, 1, cnts(0, 1, 0, 0)));
        t = tb_ts;
        cyc(4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, mk("b2b_clear2", 4'b1000, 4'b1000, t, 1, 1, cnts(1, 0, 0, 0)));
        cyc(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, mk("b2b_after", 4'b1000, 4'b1000, t, 1, 0, cnts(1, 0, 0, 1)));
    endtask

    task automatic test_srst_wrap();
        do_reset();
        cyc(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, mk("ts_zero_after_srst", 4'b0001, 4'b0001, 0, 1, 1, cnts(0, 0, 0, 1)));
        do_reset();
        while (tb_ts != 8'd255)
            cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, mk("wait_ts255", 0, 0, 0, 0, 0, 0));
        cyc(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, mk("cap_ts255", 4'b0100, 4'b0100, 255, 1, 1, cnts(0, 1, 0, 0)));
        cyc(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, mk("ts_wrap_0", 4'b0001, 4'b0001, 0, 1, 1, cnts(0, 0, 0, 1)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_lock();
        test_lock_hold();
        test_accumulate();
        test_mask();
        test_clear();
        test_back_to_back();
        test_srst_wrap();
        @(negedge clk);
        i_errors = '0; i_clear = 1'b0;
        @(posedge clk);
        #3;
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
